// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor/accumulator: WIDTH bits processed CHUNK bits per cycle, LSB first.
// Optional saturation on signed overflow when CHUNKED_ADDER_SAT_EN is defined.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_LOAD = 2'b11} op_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] x_q, y_q, part_q, acc_q, sum_q;
  logic             c_q, carry_q, ovf_q, zero_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] x_d, y_d, part_d, sum_d;
  logic             c_d, chunk_c, carry_d, ovf_d, zero_d;
  logic [CHUNK-1:0] chunk_s;
  int               base;

  // Operand selection for the operation being accepted
  always_comb begin
    x_d = A;
    y_d = '0;
    c_d = 1'b0;
    unique case (op_e'(Op))
      OP_ADD:  y_d = B;
      OP_SUB:  begin y_d = ~B; c_d = 1'b1; end
      OP_ACC:  begin x_d = acc_q; y_d = A; end
      OP_LOAD: y_d = '0;
      default: y_d = '0;
    endcase
  end

  // One chunk of the ripple add; part_d is only published to Sum after the final chunk
  always_comb begin
    base = int'(cnt_q) * CHUNK;
    {chunk_c, chunk_s} = {1'b0, x_q[base +: CHUNK]} + {1'b0, y_q[base +: CHUNK]}
                       + (CHUNK + 1)'(c_q);
    part_d = part_q;
    part_d[base +: CHUNK] = chunk_s;
    carry_d = chunk_c;
    ovf_d   = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (part_d[WIDTH-1] != x_q[WIDTH-1]);
    if (op_q == OP_LOAD) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end
    sum_d = part_d;
`ifdef CHUNKED_ADDER_SAT_EN
    if (ovf_d)
      sum_d = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    zero_d = (sum_d == '0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      part_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (En) begin
      unique case (state_q)
        S_IDLE: begin
          if (In_valid) begin
            op_q    <= op_e'(Op);
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            part_q  <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          part_q <= part_d;
          c_q    <= chunk_c;
          if (cnt_q == LAST) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            if (op_q == OP_ACC || op_q == OP_LOAD)
              acc_q <= sum_d;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (Out_ready)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign In_ready  = (state_q == S_IDLE);
  assign Out_valid = (state_q == S_DONE);
  assign Sum       = sum_q;
  assign Carry     = carry_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;

endmodule
